// File: rtl/cam_pkg.sv
// Shared tokens, state encoding and table-entry helpers for the OV7670
// configuration sequencer.
package cam_pkg;

    localparam logic [15:0] CAM_TOK_DELAY = 16'hFF_F0;
    localparam logic [15:0] CAM_TOK_END   = 16'hFF_FF;
    localparam logic [7:0]  CAM_TOK_REG   = 8'hFF;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_SEND   = 4'd3,
        ST_ACK_LO = 4'd4,
        ST_ACK_HI = 4'd5,
        ST_DELAY  = 4'd6,
        ST_NEXT   = 4'd7,
        ST_DONE   = 4'd8
    } cam_state_e;

    // Any entry addressed to reg FF that is not the delay token ends the table.
    function automatic logic cam_is_end(input logic [15:0] entry);
        return (entry[15:8] == CAM_TOK_REG) && (entry != CAM_TOK_DELAY);
    endfunction

endpackage

// File: rtl/cam_delay_timer.sv
// Down-counting settle timer: load arms CYCLES-1, count decrements, and
// expired_o flags the last cycle of the settle window.
module cam_delay_timer #(
    parameter int unsigned CYCLES = 1000
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic load_i,
    input  logic count_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(CYCLES + 32'd1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins, then decrement while counting, saturating at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(CYCLES - 32'd1);
        end else if (count_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/cam_config_seq.sv
// Walks the camera init table in ROM and pushes each {reg,data} entry to the
// SCCB write engine, honouring settle-delay and end-of-table tokens.
module cam_config_seq
    import cam_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 25_000_000,
    parameter int unsigned DELAY_MS = 10
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_start,
    output logic [7:0]  o_rom_addr,
    input  logic [15:0] i_rom_dout,
    output logic        o_sccb_start,
    output logic [7:0]  o_sccb_reg,
    output logic [7:0]  o_sccb_data,
    input  logic        i_sccb_ready,
    output logic        o_busy,
    output logic        o_done
);

    localparam int unsigned DELAY_CYCLES = (CLK_FREQ / 32'd1000) * DELAY_MS;

    cam_state_e  state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  data_q, data_d;
    logic        start_q, start_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        tmr_load_s;
    logic        tmr_count_s;
    logic        tmr_expired_s;

    cam_delay_timer #(
        .CYCLES (DELAY_CYCLES)
    ) u_delay_timer (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .load_i    (tmr_load_s),
        .count_i   (tmr_count_s),
        .expired_o (tmr_expired_s)
    );

    // Next-state, address, latched write payload and start pulse.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        reg_d       = reg_q;
        data_d      = data_q;
        start_d     = 1'b0;
        tmr_load_s  = 1'b0;
        tmr_count_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    state_d = ST_FETCH;
                    addr_d  = 8'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (cam_is_end(i_rom_dout)) begin
                    state_d = ST_DONE;
                end else if (i_rom_dout == CAM_TOK_DELAY) begin
                    state_d    = ST_DELAY;
                    tmr_load_s = 1'b1;
                end else begin
                    state_d = ST_SEND;
                    reg_d   = i_rom_dout[15:8];
                    data_d  = i_rom_dout[7:0];
                end
            end
            ST_SEND: begin
                if (i_sccb_ready) begin
                    state_d = ST_ACK_LO;
                    start_d = 1'b1;
                end else begin
                    state_d = ST_SEND;
                end
            end
            // The engine must first drop ready, so a stale high ready cannot end the write.
            ST_ACK_LO: begin
                if (!i_sccb_ready) begin
                    state_d = ST_ACK_HI;
                end else begin
                    state_d = ST_ACK_LO;
                end
            end
            ST_ACK_HI: begin
                if (i_sccb_ready) begin
                    state_d = ST_NEXT;
                end else begin
                    state_d = ST_ACK_HI;
                end
            end
            ST_DELAY: begin
                if (tmr_expired_s) begin
                    state_d = ST_NEXT;
                end else begin
                    state_d     = ST_DELAY;
                    tmr_count_s = 1'b1;
                end
            end
            ST_NEXT: begin
                if (addr_q == 8'hFF) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FETCH;
                    addr_d  = addr_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status flags follow the state being entered so they change with it.
    always_comb begin
        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            addr_q  <= 8'd0;
            reg_q   <= 8'd0;
            data_q  <= 8'd0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_rom_addr   = addr_q;
    assign o_sccb_start = start_q;
    assign o_sccb_reg   = reg_q;
    assign o_sccb_data  = data_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_cam_config_seq.sv
// Self-checking bench for cam_config_seq: behavioural ROM and SCCB engine,
// table-level model of the expected write stream, per-cycle compare process.
module tb_cam_config_seq;

    localparam int unsigned CLK_FREQ = 100_000;
    localparam int unsigned DELAY_MS = 10;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [7:0]  rom_addr;
    logic [15:0] rom_dout;
    logic        sccb_start;
    logic [7:0]  sccb_reg;
    logic [7:0]  sccb_data;
    logic        sccb_ready;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    cam_config_seq #(
        .CLK_FREQ (CLK_FREQ),
        .DELAY_MS (DELAY_MS)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_start      (start),
        .o_rom_addr   (rom_addr),
        .i_rom_dout   (rom_dout),
        .o_sccb_start (sccb_start),
        .o_sccb_reg   (sccb_reg),
        .o_sccb_data  (sccb_data),
        .i_sccb_ready (sccb_ready),
        .o_busy       (busy),
        .o_done       (done)
    );

    // Behavioural ROM, one-cycle registered read.
    logic [15:0] rom [0:255];
    always @(posedge clk) rom_dout <= rom[rom_addr];

    // SCCB engine: ready drops for 20 cycles after each accepted request.
    int   sccb_cnt = 0;
    logic force_low = 1'b0;
    always @(posedge clk) begin
        if (sccb_start) sccb_cnt <= 20;
        else if (sccb_cnt > 0) sccb_cnt <= sccb_cnt - 1;
    end
    assign sccb_ready = (sccb_cnt == 0) && !force_low;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Table model: what writes must come out and where the address must stop.
    logic [15:0] exp_q[$];
    int          exp_total;
    int          exp_final_addr;

    function automatic void build_model();
        exp_q.delete();
        exp_final_addr = 255;
        for (int a = 0; a < 256; a++) begin
            if (rom[a][15:8] == 8'hFF) begin
                if (rom[a] != 16'hFFF0) begin
                    exp_final_addr = a;
                    break;
                end
            end else begin
                exp_q.push_back(rom[a]);
            end
        end
        exp_total = exp_q.size();
    endfunction

    // Compare process, sampled 1 time unit after each rising edge.
    int          cyc = 0;
    int          pulse_cnt = 0;
    int          pulse_cyc[$];
    int          xend_cyc[$];
    logic        in_xact = 1'b0;
    logic        seen_low = 1'b0;
    logic        prev_start = 1'b0;
    logic [7:0]  prev_addr = 8'd0;
    logic [7:0]  cap_reg, cap_data;
    logic [15:0] e;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rstn) begin
            in_xact    = 1'b0;
            prev_start = 1'b0;
            prev_addr  = rom_addr;
        end else begin
            if (sccb_start) begin
                pulse_cnt++;
                pulse_cyc.push_back(cyc);
                chk("single_cycle_pulse", 32'(prev_start), 32'd0);
                chk("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("write_reg", 32'(sccb_reg), 32'(e[15:8]));
                    chk("write_data", 32'(sccb_data), 32'(e[7:0]));
                end
                in_xact  = 1'b1;
                seen_low = 1'b0;
                cap_reg  = sccb_reg;
                cap_data = sccb_data;
            end else if (in_xact) begin
                chk("reg_stable", 32'(sccb_reg), 32'(cap_reg));
                chk("data_stable", 32'(sccb_data), 32'(cap_data));
                if (!sccb_ready) begin
                    seen_low = 1'b1;
                end else if (seen_low) begin
                    in_xact = 1'b0;
                    xend_cyc.push_back(cyc);
                end
            end
            if (rom_addr != prev_addr) begin
                chk("addr_step", 32'(({1'b0, rom_addr} == {1'b0, prev_addr} + 9'd1) ||
                                     (rom_addr == 8'd0 && start)), 32'd1);
            end
            chk("busy_done_exclusive", 32'(busy && done), 32'd0);
            prev_start = sccb_start;
            prev_addr  = rom_addr;
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    // Start a full run and check its table-level outcome against the model.
    task automatic run_table(input string name, input int budget);
        int base;
        build_model();
        base = pulse_cnt;
        pulse_start();
        chk({name, "_addr0"}, 32'(rom_addr), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd1);
        chk({name, "_done_clr"}, 32'(done), 32'd0);
        wait_done(budget, {name, "_done"});
        chk({name, "_writes"}, pulse_cnt - base, exp_total);
        chk({name, "_pending"}, exp_q.size(), 32'd0);
        chk({name, "_final_addr"}, 32'(rom_addr), exp_final_addr);
        chk({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic clear_rom();
        for (int a = 0; a < 256; a++) rom[a] = 16'hFFFF;
    endtask

    task automatic wait_pulses(input int target, input int budget, input string name);
        int k = 0;
        while (pulse_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(pulse_cnt >= target), 32'd1);
    endtask

    initial begin
        int b;
        int xb;
        int base;
        rstn  = 1'b0;
        start = 1'b0;
        clear_rom();
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_start", 32'(sccb_start), 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("rel_addr", 32'(rom_addr), 32'd0);
        chk("rel_reg", 32'({sccb_reg, sccb_data}), 32'd0);
        chk("rel_busy", 32'(busy), 32'd0);

        // Two plain writes then end.
        rom[0] = 16'h1204; rom[1] = 16'h1100; rom[2] = 16'hFFFF;
        build_model();
        chk("model_t1_writes", exp_total, 32'd2);
        chk("model_t1_final", exp_final_addr, 32'd2);
        run_table("t1", 400);

        // Settle delay between writes.
        clear_rom();
        rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1204; rom[3] = 16'hFFFF;
        build_model();
        chk("model_t2_final", exp_final_addr, 32'd3);
        b  = pulse_cyc.size();
        xb = xend_cyc.size();
        run_table("t2", 2000);
        chk("t2_have_events", 32'(pulse_cyc.size() >= b + 2 && xend_cyc.size() > xb), 32'd1);
        if (pulse_cyc.size() >= b + 2 && xend_cyc.size() > xb)
            chk("t2_delay_gap", 32'((pulse_cyc[b+1] - xend_cyc[xb]) >= 1000), 32'd1);

        // Engine busy for 500 cycles before the first write.
        clear_rom();
        rom[0] = 16'h1204; rom[1] = 16'h1100; rom[2] = 16'hFFFF;
        build_model();
        base = pulse_cnt;
        force_low = 1'b1;
        pulse_start();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            chk("t3_no_pulse", 32'(sccb_start), 32'd0);
            chk("t3_busy", 32'(busy), 32'd1);
        end
        force_low = 1'b0;
        @(negedge clk);
        chk("t3_pulse_after_ready", 32'(sccb_start), 32'd1);
        wait_done(400, "t3_done");
        chk("t3_writes", pulse_cnt - base, 32'd2);

        // Reset during ACK_LO of entry 3, then restart.
        clear_rom();
        rom[0] = 16'h1204; rom[1] = 16'h1100; rom[2] = 16'h3A04;
        rom[3] = 16'h4010; rom[4] = 16'hFFFF;
        build_model();
        base = pulse_cnt;
        pulse_start();
        wait_pulses(base + 3, 400, "t4_reach_entry3");
        rstn = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("t4_rst_addr", 32'(rom_addr), 32'd0);
        chk("t4_rst_start", 32'(sccb_start), 32'd0);
        chk("t4_rst_reg", 32'(sccb_reg), 32'd0);
        chk("t4_rst_data", 32'(sccb_data), 32'd0);
        chk("t4_rst_busy", 32'(busy), 32'd0);
        chk("t4_rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        base = pulse_cnt;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("t4_quiet_start", 32'(sccb_start), 32'd0);
            chk("t4_quiet_busy", 32'(busy), 32'd0);
        end
        chk("t4_no_pulses", pulse_cnt - base, 32'd0);
        run_table("t4_restart", 600);

        // Full 256-entry table with no end marker.
        for (int a = 0; a < 256; a++) begin
            logic [7:0] av;
            av = a[7:0];
            rom[a] = {1'b0, av[6:0], av};
        end
        build_model();
        chk("model_t5_writes", exp_total, 32'd256);
        run_table("t5", 20000);

        // Start while busy is ignored; start after done replays.
        clear_rom();
        rom[0] = 16'h1204; rom[1] = 16'h1100; rom[2] = 16'hFFFF;
        build_model();
        base = pulse_cnt;
        pulse_start();
        wait_pulses(base + 1, 100, "t6_first_pulse");
        pulse_start();
        chk("t6_still_busy", 32'(busy), 32'd1);
        wait_done(400, "t6_done");
        chk("t6_writes", pulse_cnt - base, 32'd2);
        chk("t6_final_addr", 32'(rom_addr), 32'd2);
        run_table("t6_replay", 400);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
